// File: rtl/vga_frame_ctrl_pkg.sv
// vga_pkg: shared VGA timing constants, widths and the game-state snapshot type.
package vga_pkg;
  localparam int CLK_DIV  = 4;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CNT_W    = 10;
  localparam int RGB_W    = 12;
  localparam int N_OBS    = 20;
  localparam int OBS_X_W  = 10;
  localparam int OBS_Y_W  = 9;
  typedef struct packed {
    logic [1:0]               gamemode;
    logic [8:0]               player_y;
    logic [N_OBS*OBS_X_W-1:0] obstacle_x;
    logic [N_OBS*OBS_Y_W-1:0] obstacle_y;
  } snap_t;
endpackage

// File: rtl/vga_frame_ctrl_if.sv
// vga_frame_ctrl_if: valid/ready snapshot channel from game logic into the frame controller.
interface vga_frame_ctrl_if;
  import vga_pkg::*;
  logic                     upd_valid;
  logic                     upd_ready;
  logic [1:0]               gamemode_in;
  logic [8:0]               player_y_in;
  logic [N_OBS*OBS_X_W-1:0] obstacle_x_in;
  logic [N_OBS*OBS_Y_W-1:0] obstacle_y_in;
  modport master (output upd_valid, gamemode_in, player_y_in, obstacle_x_in, obstacle_y_in, input upd_ready);
  modport slave (input upd_valid, gamemode_in, player_y_in, obstacle_x_in, obstacle_y_in, output upd_ready);
endinterface

// File: rtl/vga_frame_ctrl_timing_gen.sv
// vga_timing_gen: pixel-enable divider plus h/v counters with raw syncs, active and frame tick.
module vga_timing_gen #(
  parameter int CLK_DIV  = vga_pkg::CLK_DIV,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      pix_en,
  output logic [vga_pkg::CNT_W-1:0] h_cnt,
  output logic [vga_pkg::CNT_W-1:0] v_cnt,
  output logic                      active,
  output logic                      hsync_raw,
  output logic                      vsync_raw,
  output logic                      frame_tick
);
  localparam int CW  = vga_pkg::CNT_W;
  localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS0 = H_ACTIVE + H_FP;
  localparam int VS0 = V_ACTIVE + V_FP;
  localparam int DW  = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic          h_wrap;
  always_comb begin
    pix_en     = div_q == DW'(CLK_DIV - 1);
    div_d      = pix_en ? '0 : div_q + 1'b1;
    h_wrap     = h_q == CW'(HT - 1);
    h_d        = pix_en ? (h_wrap ? '0 : h_q + 1'b1) : h_q;
    v_d        = (pix_en && h_wrap) ? (v_q == CW'(VT - 1) ? '0 : v_q + 1'b1) : v_q;
    active     = (h_q < CW'(H_ACTIVE)) && (v_q < CW'(V_ACTIVE));
    hsync_raw  = !((h_q >= CW'(HS0)) && (h_q < CW'(HS0 + H_SYNC)));
    vsync_raw  = !((v_q >= CW'(VS0)) && (v_q < CW'(VS0 + V_SYNC)));
    frame_tick = pix_en && h_wrap && (v_q == CW'(V_ACTIVE - 1));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end
  assign h_cnt = h_q;
  assign v_cnt = v_q;
endmodule

// File: rtl/vga_frame_ctrl.sv
// vga_frame_ctrl: VGA timing, one-pixel output register stage and a vblank-swapped game-state snapshot.
module vga_frame_ctrl import vga_pkg::*; #(
  parameter int CLK_DIV  = vga_pkg::CLK_DIV,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic                     clk,
  input  logic                     rst_n,
  vga_frame_ctrl_if.slave          upd,
  output logic [9:0]               pix_x,
  output logic [8:0]               pix_y,
  output logic [1:0]               gamemode,
  output logic [8:0]               player_y,
  output logic [N_OBS*OBS_X_W-1:0] obstacle_x,
  output logic [N_OBS*OBS_Y_W-1:0] obstacle_y,
  input  logic [RGB_W-1:0]         rgb_in,
  output logic [RGB_W-1:0]         vga_rgb,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     frame_tick
);
  logic             pix_en, active, hsync_raw, vsync_raw, accept, swap;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  snap_t            pend_q, pend_d, disp_q, disp_d;
  logic             pend_full_q, pend_full_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic [RGB_W-1:0] vga_rgb_q, vga_rgb_d;
  vga_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .h_cnt(h_cnt), .v_cnt(v_cnt), .active(active),
    .hsync_raw(hsync_raw), .vsync_raw(vsync_raw), .frame_tick(frame_tick)
  );
  // accept needs an empty pending buffer and swap a full one, so the two never coincide
  always_comb begin
    accept      = upd.upd_valid && !pend_full_q;
    swap        = frame_tick && pend_full_q;
    pend_d      = accept ? snap_t'{upd.gamemode_in, upd.player_y_in, upd.obstacle_x_in, upd.obstacle_y_in} : pend_q;
    disp_d      = swap ? pend_q : disp_q;
    pend_full_d = swap ? 1'b0 : (accept ? 1'b1 : pend_full_q);
    vga_rgb_d   = pix_en ? (active ? rgb_in : '0) : vga_rgb_q;
    hsync_d     = pix_en ? hsync_raw : hsync_q;
    vsync_d     = pix_en ? vsync_raw : vsync_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      disp_q      <= '0;
      pend_full_q <= 1'b0;
      vga_rgb_q   <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
    end else begin
      pend_q      <= pend_d;
      disp_q      <= disp_d;
      pend_full_q <= pend_full_d;
      vga_rgb_q   <= vga_rgb_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
    end
  end
  assign upd.upd_ready = !pend_full_q;
  assign pix_x         = active ? h_cnt : '0;
  assign pix_y         = active ? 9'(v_cnt) : '0;
  assign gamemode      = disp_q.gamemode;
  assign player_y      = disp_q.player_y;
  assign obstacle_x    = disp_q.obstacle_x;
  assign obstacle_y    = disp_q.obstacle_y;
  assign vga_rgb       = vga_rgb_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
endmodule

// File: tb/tb_vga_frame_ctrl.sv
// tb_vga_frame_ctrl: directed checks on a shrunken timing (15x10 pixels, CLK_DIV=2, 300 clk per frame).
module tb_vga_frame_ctrl;
  import vga_pkg::*;
  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [9:0]               pix_x;
  logic [8:0]               pix_y, player_y;
  logic [1:0]               gamemode;
  logic [N_OBS*OBS_X_W-1:0] obstacle_x;
  logic [N_OBS*OBS_Y_W-1:0] obstacle_y;
  logic [RGB_W-1:0]         rgb_in, vga_rgb;
  logic                     hsync, vsync, frame_tick;
  int checks = 0, errors = 0, c = 0;
  int hs_low, vs_low, ft_cnt, ft_first, hs_first, vs_first, rgb_on, rgb_bad;
  logic [N_OBS*OBS_X_W-1:0] ox1, ox2;
  logic [N_OBS*OBS_Y_W-1:0] oy1, oy2;
  vga_frame_ctrl_if u_if ();
  vga_frame_ctrl #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .upd(u_if), .pix_x(pix_x), .pix_y(pix_y), .gamemode(gamemode),
    .player_y(player_y), .obstacle_x(obstacle_x), .obstacle_y(obstacle_y), .rgb_in(rgb_in),
    .vga_rgb(vga_rgb), .hsync(hsync), .vsync(vsync), .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    c++;
  endtask
  task automatic run_to(input int target);
    while (c < target) tick();
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hsync"}, 256'(hsync), 256'(1));
    chk({tag, "_vsync"}, 256'(vsync), 256'(1));
    chk({tag, "_rgb"}, 256'(vga_rgb), 256'(0));
    chk({tag, "_ready"}, 256'(u_if.upd_ready), 256'(1));
    chk({tag, "_ftick"}, 256'(frame_tick), 256'(0));
    chk({tag, "_mode"}, 256'(gamemode), 256'(0));
    chk({tag, "_py"}, 256'(player_y), 256'(0));
    chk({tag, "_obx"}, 256'(obstacle_x), 256'(0));
    chk({tag, "_pix_x"}, 256'(pix_x), 256'(0));
    chk({tag, "_pix_y"}, 256'(pix_y), 256'(0));
  endtask
  initial begin
    ox1 = {N_OBS{10'h2A5}};
    oy1 = {N_OBS{9'h0C3}};
    ox2 = {N_OBS{10'h155}};
    oy2 = {N_OBS{9'h13C}};
    rgb_in = 12'hABC;
    u_if.upd_valid = 1'b0;
    u_if.gamemode_in = 2'd0;
    u_if.player_y_in = 9'd0;
    u_if.obstacle_x_in = '0;
    u_if.obstacle_y_in = '0;
    tick();
    tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    c = 0;
    chk("px_c0", 256'(pix_x), 256'(0));
    tick();
    chk("px_c1", 256'(pix_x), 256'(0));
    chk("rgb_c1", 256'(vga_rgb), 256'(0));
    tick();
    chk("px_c2", 256'(pix_x), 256'(1));
    chk("rgb_c2", 256'(vga_rgb), 256'(12'hABC));
    tick();
    tick();
    chk("px_c4", 256'(pix_x), 256'(2));
    hs_low = 0; vs_low = 0; ft_cnt = 0; rgb_on = 0; rgb_bad = 0;
    ft_first = -1; hs_first = -1; vs_first = -1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!hsync) begin hs_low++; if (hs_first < 0) hs_first = c; end
      if (!vsync) begin vs_low++; if (vs_first < 0) vs_first = c; end
      if (frame_tick) begin ft_cnt++; if (ft_first < 0) ft_first = c; end
      if (vga_rgb == 12'hABC) rgb_on++;
      else if (vga_rgb != 12'h000) rgb_bad++;
      if (c == 40) chk("pix_c40", 256'({pix_y, pix_x}), 256'({9'd1, 10'd5}));
      if (c == 65) chk("pix_c65", 256'({pix_y, pix_x}), 256'({9'd2, 10'd2}));
      if (c == 20) chk("pix_hblank", 256'({pix_y, pix_x}), 256'(0));
      if (c == 200) chk("pix_vblank", 256'({pix_y, pix_x}), 256'(0));
    end
    chk("hs_low_clk", 256'(hs_low), 256'(60));
    chk("hs_first", 256'(hs_first), 256'(22));
    chk("vs_low_clk", 256'(vs_low), 256'(60));
    chk("vs_first", 256'(vs_first), 256'(212));
    chk("ft_count", 256'(ft_cnt), 256'(1));
    chk("ft_first", 256'(ft_first), 256'(179));
    chk("rgb_on_clk", 256'(rgb_on), 256'(96));
    chk("rgb_bad", 256'(rgb_bad), 256'(0));
    chk("ready_idle", 256'(u_if.upd_ready), 256'(1));
    u_if.upd_valid = 1'b1;
    u_if.gamemode_in = 2'd1;
    u_if.player_y_in = 9'd200;
    u_if.obstacle_x_in = ox1;
    u_if.obstacle_y_in = oy1;
    tick();
    chk("ready_drop", 256'(u_if.upd_ready), 256'(0));
    chk("py_held", 256'(player_y), 256'(0));
    u_if.gamemode_in = 2'd2;
    u_if.player_y_in = 9'd300;
    u_if.obstacle_x_in = ox2;
    u_if.obstacle_y_in = oy2;
    tick();
    chk("stall_ready", 256'(u_if.upd_ready), 256'(0));
    run_to(478);
    chk("pre_ft", 256'({frame_tick, u_if.upd_ready}), 256'(0));
    chk("pre_ft_py", 256'(player_y), 256'(0));
    tick();
    chk("ft_c479", 256'(frame_tick), 256'(1));
    chk("ft_c479_py", 256'(player_y), 256'(0));
    tick();
    chk("swap_py", 256'(player_y), 256'(200));
    chk("swap_mode", 256'(gamemode), 256'(1));
    chk("swap_obx", 256'(obstacle_x), 256'(ox1));
    chk("swap_oby", 256'(obstacle_y), 256'(oy1));
    chk("swap_ready", 256'(u_if.upd_ready), 256'(1));
    chk("ft_c480", 256'(frame_tick), 256'(0));
    tick();
    chk("second_acc", 256'(u_if.upd_ready), 256'(0));
    u_if.upd_valid = 1'b0;
    run_to(605);
    chk("pre_rst_pix", 256'({pix_y, pix_x}), 256'({9'd0, 10'd2}));
    chk("pre_rst_rgb", 256'(vga_rgb), 256'(12'hABC));
    chk("pre_rst_py", 256'(player_y), 256'(200));
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    c = 0;
    chk("rel_pix", 256'({pix_y, pix_x}), 256'(0));
    tick();
    tick();
    chk("rel_px_c2", 256'(pix_x), 256'(1));
    run_to(30);
    chk("rel_line1", 256'({pix_y, pix_x}), 256'({9'd1, 10'd0}));
    run_to(181);
    chk("rel_no_swap", 256'({gamemode, player_y}), 256'(0));
    chk("rel_ready", 256'(u_if.upd_ready), 256'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_frame_ctrl.md
Name: vga_frame_ctrl

Overview:
- Sequences the combinational renderer `vga_screen_pic`.
- Generates 640x480@60 VGA timing from the system clock and drives `pix_x`/`pix_y` into the renderer.
- Registers the renderer's `rgb` together with delay-matched syncs.
- Owns a double-buffered snapshot of game state (`gamemode`, `player_y`, `obstacle_x`, `obstacle_y`). The renderer only sees state that changes in vertical blanking, so there is no tearing.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); must be >=1
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- N_OBS, 20, obstacle slots (x 10 bits, y 9 bits each)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- upd_valid  in  1  game logic offers a new state snapshot
- upd_ready  out  1  pending buffer empty; snapshot will be accepted
- gamemode_in  in  2  new game mode
- player_y_in  in  9  new player Y
- obstacle_x_in  in  10*N_OBS  new obstacle X, packed
- obstacle_y_in  in  9*N_OBS  new obstacle Y, packed
- pix_x  out  10  current pixel X to renderer
- pix_y  out  9  current pixel Y to renderer
- gamemode  out  2  displayed mode to renderer
- player_y  out  9  displayed player Y
- obstacle_x  out  10*N_OBS  displayed obstacle X
- obstacle_y  out  9*N_OBS  displayed obstacle Y
- rgb_in  in  12  renderer output for current pix_x/pix_y
- vga_rgb  out  12  registered pixel to DAC ({r,g,b} 4 bits each)
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- frame_tick  out  1  one-clk pulse at start of vertical blank

Behaviour:
- Clock and reset: single clock domain on `clk`; reset is asynchronous and active-low on `rst_n`.
- Pixel enable:
  - Divider counts 0..CLK_DIV-1; pix_en=1 when the divider is at CLK_DIV-1.
  - CLK_DIV=1 gives pix_en constantly 1.
- Counters (advance only on pix_en):
  - h_cnt runs 0..H_TOTAL-1 (800) and wraps to 0.
  - v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1 (525) before wrapping.
- Stage 0:
  - active = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
  - pix_x = active ? h_cnt : 0 and pix_y = active ? v_cnt[8:0] : 0, driven from registers.
- Stage 1 (register on pix_en):
  - vga_rgb <= active_d ? rgb_in : 0.
  - hsync <= !(h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]), i.e. 656..751.
  - vsync <= !(v_cnt in [490, 491]).
  - Syncs are delayed through the same stage as rgb, so all outputs align.
- Latency:
  - pix_x/pix_y to vga_rgb is exactly one pixel (CLK_DIV clocks).
  - The renderer path is combinational and must settle within one pixel period.
- frame_tick: high for exactly one clk, in the cycle where pix_en && h_cnt==H_TOTAL-1 && v_cnt==V_ACTIVE-1.
- Snapshot handshake:
  - upd_ready = !pend_full.
  - On upd_valid && upd_ready, the *_in buses latch into pending registers and pend_full<=1.
  - The producer holds data stable while valid && !ready.
- Display swap:
  - In the frame_tick cycle, if pend_full, copy pending to the display outputs and set pend_full<=0. upd_ready rises the next cycle.
  - Display outputs change only in that cycle.
- Simultaneous accept and frame_tick: pend_full was 0, so no swap happens. The accepted data waits for the next frame_tick.
- Back-to-back offers: a second offer while pend_full=1 is stalled (ready=0) until the swap.
- Reset values:
  - All counters 0; pend_full 0 (so upd_ready=1).
  - Display and pending regs all 0; gamemode 2'b00 (menu).
  - vga_rgb 0; hsync 1 and vsync 1 (deasserted); frame_tick 0.
- Reset mid-frame: asynchronous clear to the values above. Timing restarts at (0,0) on the first pix_en after release.
- Width rules:
  - h_cnt and v_cnt are each 10 bits.
  - pix_y is truncated to 9 bits only when active (v_cnt<480 fits).

Decomposition:
- Shared package `vga_pkg`: the timing constants (H_*/V_* values, H_TOTAL=800, V_TOTAL=525), the 12-bit colour width, N_OBS, and the per-obstacle X/Y widths (10/9).
- One natural sub-module, `vga_timing_gen`: divider plus h/v counters, emitting pix_en, h_cnt, v_cnt, active, hsync_raw, vsync_raw and frame_tick.
- The snapshot buffer and output stage stay in the top.

Test Plan:
- Release reset with CLK_DIV=4 -> hsync=1, vsync=1, vga_rgb=0, upd_ready=1; first pix_en after 4 clk; pix_x counts 0,1,2.
- Run one line -> hsync low for exactly 384 clk, starting at h_cnt=656 plus one pixel delay; period 3200 clk.
- Run a full frame -> vsync low over lines 490-491; frame_tick period 1,680,000 clk with exactly one 1-clk pulse.
- Constant rgb_in=12'hABC -> vga_rgb=12'hABC only for 640x480 pixels per frame; 0 in blanking.
- Offer player_y_in=200, gamemode_in=01 at line 100 -> ready drops next clk; player_y stays old until the frame_tick cycle, then 200; ready returns 1.
- Second offer while pend_full=1, then assert rst_n=0 at line 300 -> first the offer stalls with ready=0 and data held; on reset all outputs return to reset values immediately, and the next frame starts at pix_x=0, pix_y=0.
